// File: rtl/mkio_pkg.sv
// Shared MIL-STD-1553B word constants and encoding helpers for the mkio channel transmitter/receiver.
package mkio_pkg;

  localparam logic [5:0] SYNC_CMD      = 6'b111000;
  localparam logic [5:0] SYNC_DATA     = 6'b000111;
  localparam int         WORD_HALFBITS = 40;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  function automatic logic odd_parity(input logic [15:0] data);
    return ~^data;
  endfunction

  // Half-bit image of a word, MSB goes on the line first; bad=1 inverts the parity half-bits.
  function automatic logic [39:0] encode_word(input logic sync, input logic [15:0] data,
                                              input logic bad);
    logic [39:0] w;
    logic        p;
    w[39:34] = sync ? SYNC_CMD : SYNC_DATA;
    for (int i = 0; i < 16; i++) begin
      w[33-2*i -: 2] = {data[15-i], ~data[15-i]};
    end
    p       = odd_parity(data) ^ bad;
    w[1:0]  = {p, ~p};
    return w;
  endfunction

endpackage

// File: rtl/mkio_halfbit_timer.sv
// Half-bit prescaler: counts 0..HALFBIT_CLKS-1 while run is high, strobes tc on the last count.
// Held at zero while not running so a new word always starts with a full-length half-bit.
module mkio_halfbit_timer #(
  parameter int HALFBIT_CLKS = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tc
);

  localparam int CW = (HALFBIT_CLKS > 2) ? $clog2(HALFBIT_CLKS) : 1;

  logic [CW-1:0] cnt;

  assign tc = run && (cnt == CW'(HALFBIT_CLKS - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run || tc) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/mkio_word_tx.sv
// Manchester II word transmitter: sync + 16 data bits + odd parity on DO1/DO0, back-to-back capable.
// Optional MKIO_TX_ERR_INJ_EN adds tx_bad_parity to corrupt the parity of a single word.
module mkio_word_tx
  import mkio_pkg::*;
#(
  parameter int HALFBIT_CLKS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_valid,
  input  logic        tx_sync,
  input  logic [15:0] tx_data,
  output logic        tx_ready,
  output logic        tx_busy,
  output logic        tx_done,
  input  logic        tx_inhibit,
`ifdef MKIO_TX_ERR_INJ_EN
  input  logic        tx_bad_parity,
`endif
  output logic        DO1,
  output logic        DO0
);

  tx_state_t   state, state_nxt;
  logic [39:0] shreg, shreg_nxt;
  logic [5:0]  idx, idx_nxt;
  logic        done_nxt;
  logic        tc;
  logic        last;
  logic        accept;
  logic        bad_sel;

`ifdef MKIO_TX_ERR_INJ_EN
  assign bad_sel = tx_bad_parity;
`else
  assign bad_sel = 1'b0;
`endif

  mkio_halfbit_timer #(
    .HALFBIT_CLKS(HALFBIT_CLKS)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .run  (state == SEND),
    .tc   (tc)
  );

  assign last     = (idx == 6'(WORD_HALFBITS - 1));
  assign tx_ready = (state == IDLE) || (last && tc);
  assign accept   = tx_valid && tx_ready;
  assign tx_busy  = (state == SEND);

  always_comb begin
    state_nxt = state;
    shreg_nxt = shreg;
    idx_nxt   = idx;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SEND;
          shreg_nxt = encode_word(tx_sync, tx_data, bad_sel);
          idx_nxt   = '0;
        end
      end
      SEND: begin
        if (tc) begin
          if (!last) begin
            shreg_nxt = {shreg[38:0], 1'b0};
            idx_nxt   = idx + 6'd1;
          end else if (accept) begin
            // Follow-on word starts on the very next cycle: no idle gap on the line.
            shreg_nxt = encode_word(tx_sync, tx_data, bad_sel);
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Line outputs are driven from next-state values so the first half-bit appears right after accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      idx     <= '0;
      tx_done <= 1'b0;
      DO1     <= 1'b0;
      DO0     <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      idx     <= idx_nxt;
      tx_done <= done_nxt;
      DO1     <= (state_nxt == SEND) && !tx_inhibit && shreg_nxt[39];
      DO0     <= (state_nxt == SEND) && !tx_inhibit && !shreg_nxt[39];
    end
  end

endmodule

// File: tb/tb_mkio_word_tx.sv
// Scoreboard bench for mkio_word_tx: expected half-bit images queued at accept, line checked every cycle.
module tb_mkio_word_tx;

  localparam int HB     = 16;
  localparam int WCLKS  = 40 * HB;

  logic        clk = 1'b0;
  logic        reset;
  logic        tx_valid, tx_sync, tx_inhibit;
  logic [15:0] tx_data;
  logic        tx_ready, tx_busy, tx_done;
  logic        DO1, DO0;
  logic        bad_par;

  mkio_word_tx #(.HALFBIT_CLKS(HB)) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_valid     (tx_valid),
    .tx_sync      (tx_sync),
    .tx_data      (tx_data),
    .tx_ready     (tx_ready),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done),
    .tx_inhibit   (tx_inhibit),
`ifdef MKIO_TX_ERR_INJ_EN
    .tx_bad_parity(bad_par),
`endif
    .DO1          (DO1),
    .DO0          (DO0)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_pass = 0;
  int          n_busy = 0, n_done = 0, n_mid_rdy = 0;
  logic [39:0] exp_q[$];
  logic [39:0] cur;
  logic        active = 1'b0, ended = 1'b0, inh_s = 1'b0;
  int          pos = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [39:0] model(input logic s, input logic [15:0] d, input logic bad);
    logic [39:0] w;
    logic        p;
    w[39:34] = s ? 6'b111000 : 6'b000111;
    for (int i = 0; i < 16; i++) begin
      w[33-2*i] = d[15-i];
      w[32-2*i] = !d[15-i];
    end
    p = (($countones(d) % 2) == 0);
    if (bad) p = !p;
    w[1] = p;
    w[0] = !p;
    return w;
  endfunction

  task automatic monitor();
    logic b;
    if (!active && exp_q.size() > 0) begin
      cur    = exp_q.pop_front();
      active = 1'b1;
      ended  = 1'b0;
      pos    = 0;
    end
    if (active) begin
      b = cur[39 - pos / HB];
      chk("do1", DO1, inh_s ? 1'b0 : b);
      chk("do0", DO0, inh_s ? 1'b0 : !b);
      chk("busy", tx_busy, 1'b1);
      chk("done_mid", tx_done, 1'b0);
      pos++;
      if (pos == WCLKS) begin
        active = 1'b0;
        ended  = 1'b1;
      end
    end else begin
      chk("done_end", tx_done, ended);
      chk("idle_line", {DO1, DO0}, 2'b00);
      chk("idle_busy", tx_busy, 1'b0);
      ended = 1'b0;
    end
  endtask

  // Inputs are stable here; sample accept, advance one clock, then check the new cycle.
  task automatic step(output logic acc);
    acc = tx_valid && tx_ready;
    if (acc) begin
      exp_q.push_back(model(tx_sync, tx_data, bad_par));
      if (tx_busy) n_mid_rdy++;
    end
    inh_s = tx_inhibit;
    @(posedge clk);
    @(negedge clk);
    if (tx_busy) n_busy++;
    if (tx_done) n_done++;
    monitor();
  endtask

  task automatic steps(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic wait_acc();
    logic a;
    int   n;
    a = 1'b0;
    n = 0;
    while (!a && n < 2000) begin
      step(a);
      n++;
    end
    if (!a) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic wait_idle();
    logic a;
    int   n;
    n = 0;
    do begin
      step(a);
      n++;
    end while (tx_busy && n < 5000);
    if (tx_busy) chk("idle_timeout", 1'b1, 1'b0);
  endtask

  task automatic start_word(input logic s, input logic [15:0] d, input logic bad);
    tx_valid = 1'b1;
    tx_sync  = s;
    tx_data  = d;
    bad_par  = bad;
    wait_acc();
    tx_valid = 1'b0;
    tx_sync  = 1'($urandom);
    tx_data  = 16'($urandom);
    bad_par  = 1'($urandom);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0, b0, r0;
    logic [15:0] dwords[3];
    dwords = '{16'h1234, 16'hFFFF, 16'h0001};
    reset = 1'b1; tx_valid = 1'b0; tx_sync = 1'b0; tx_data = '0; tx_inhibit = 1'b0; bad_par = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    chk("rst_line", {DO1, DO0}, 2'b00);
    reset = 1'b0;
    steps(3);

    // 1: status word 0x0800
    d0 = n_done; b0 = n_busy;
    start_word(1'b1, 16'h0800, 1'b0);
    wait_idle();
    chk("t1_busy_clks", n_busy - b0, WCLKS);
    chk("t1_done_cnt", n_done - d0, 1);
    steps(2);

    // 2: data word 0xFFFF
    d0 = n_done; b0 = n_busy;
    start_word(1'b0, 16'hFFFF, 1'b0);
    wait_idle();
    chk("t2_busy_clks", n_busy - b0, WCLKS);
    chk("t2_done_cnt", n_done - d0, 1);
    steps(5);

    // 3: back-to-back status + 3 data words
    d0 = n_done; b0 = n_busy; r0 = n_mid_rdy;
    tx_valid = 1'b1; tx_sync = 1'b1; tx_data = 16'h0800; bad_par = 1'b0;
    wait_acc();
    for (int k = 0; k < 3; k++) begin
      tx_sync = 1'b0;
      tx_data = dwords[k];
      wait_acc();
    end
    tx_valid = 1'b0;
    tx_data  = 16'hDEAD;
    wait_idle();
    chk("t3_busy_clks", n_busy - b0, 4 * WCLKS);
    chk("t3_mid_ready", n_mid_rdy - r0, 3);
    chk("t3_done_cnt", n_done - d0, 1);
    steps(2);

    // 4: inhibit over half-bits 10..20 of 0xA5A5
    d0 = n_done; b0 = n_busy;
    start_word(1'b0, 16'hA5A5, 1'b0);
    for (int c = 0; c < WCLKS - 1; c++) begin
      tx_inhibit = (c >= 10 * HB) && (c < 21 * HB);
      steps(1);
    end
    tx_inhibit = 1'b0;
    wait_idle();
    chk("t4_busy_clks", n_busy - b0, WCLKS);
    chk("t4_done_cnt", n_done - d0, 1);
    steps(2);

    // 5: reset mid-word
    start_word(1'b1, 16'h1234, 1'b0);
    steps(299);
    reset = 1'b1;
    #1;
    chk("t5_line", {DO1, DO0}, 2'b00);
    chk("t5_ready", tx_ready, 1'b1);
    chk("t5_busy", tx_busy, 1'b0);
    chk("t5_done", tx_done, 1'b0);
    active = 1'b0; ended = 1'b0; exp_q.delete();
    d0 = n_done;
    steps(2);
    reset = 1'b0;
    steps(2);
    chk("t5_no_done", n_done - d0, 0);
    start_word(1'b0, 16'h5A3C, 1'b0);
    wait_idle();
    chk("t5_new_done", n_done - d0, 1);
    steps(2);

`ifdef MKIO_TX_ERR_INJ_EN
    // 6: injected parity error then a clean word
    d0 = n_done;
    start_word(1'b0, 16'h0000, 1'b1);
    wait_idle();
    start_word(1'b0, 16'h0000, 1'b0);
    wait_idle();
    chk("t6_done_cnt", n_done - d0, 2);
    steps(2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
